sbox_sched: RTL and testbench

- Schedules the single shared S-box (`sbytes`: combinational, `olddata` → `newdata`) between two requesters:
  - SubBytes pass: 16 state bytes in SRAM, substituted in place.
  - Key-expansion SubWord request: 4 bytes passed directly, no SRAM.
- Owns the SRAM byte port during a pass and drives the S-box enable and input.
- Sits between the AES round controller and the key scheduler.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/sbox_sched.sv | 151 +++++++++++++++
 tb/tb_sbox_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg : shared types and constants for the AES S-box scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int NBYTES    = 16;
  localparam int KEY_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_KEY   = 3'd4,
    S_KACK  = 3'd5,
    S_DONE  = 3'd6
  } sched_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Reference S-box: multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gf_mul(b, a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbox_sched.sv
// ---------------------------------------------------------------------------
// sbox_sched : arbitrates one shared S-box between an in-SRAM SubBytes pass
//              and key-expansion SubWord requests.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sbox_sched
  import aes_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NBYTES = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sbytes_enable,
  input  logic [ADDR_W-1:0] state_base,
  output logic              sbytes_finished,
  input  logic              key_req,
  input  logic [31:0]       key_word,
  output logic              key_ack,
  output logic [31:0]       key_result,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_read_en,
  output logic              sram_write_en,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sbox_en,
  output logic [7:0]        sbox_in,
  input  logic [7:0]        sbox_out
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  sched_state_t      state;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        k;
  logic              last_key;
  logic              pass_act;
  logic [7:0]        byte_q;
  logic [23:0]       key_acc;
  logic [31:0]       key_result_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      k            <= 2'd0;
      last_key     <= 1'b0;
      pass_act     <= 1'b0;
      byte_q       <= 8'h00;
      key_acc      <= 24'h0;
      key_result_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          // Key has priority; a simultaneous pass start is remembered and run after the ack.
          if (key_req) begin
            state    <= S_KEY;
            k        <= 2'd0;
            idx      <= '0;
            pass_act <= sbytes_enable;
          end else if (sbytes_enable) begin
            state    <= S_READ;
            idx      <= '0;
            pass_act <= 1'b1;
          end
        end
        S_READ: state <= S_CALC;
        S_CALC: begin
          byte_q <= sbox_out;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          last_key <= 1'b0;
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
            if (key_req && !last_key) begin
              state <= S_KEY;
              k     <= 2'd0;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_KEY: begin
          // The full word is published on entry to KACK so key_result never shows a partial word.
          case (k)
            2'd0: key_acc[7:0]   <= sbox_out;
            2'd1: key_acc[15:8]  <= sbox_out;
            2'd2: key_acc[23:16] <= sbox_out;
            default: key_result_q <= {sbox_out, key_acc};
          endcase
          if (k == 2'd3) state <= S_KACK;
          else           k     <= k + 2'd1;
        end
        S_KACK: begin
          last_key <= 1'b1;
          state    <= pass_act ? S_READ : S_IDLE;
        end
        S_DONE: begin
          idx      <= '0;
          pass_act <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sram_addr       = '0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    sram_wdata      = 8'h00;
    sbox_en         = 1'b0;
    sbox_in         = 8'h00;
    sbytes_finished = 1'b0;
    key_ack         = 1'b0;
    case (state)
      S_READ: begin
        sram_addr    = state_base + ADDR_W'(idx);
        sram_read_en = 1'b1;
      end
      S_CALC: begin
        sbox_en = 1'b1;
        sbox_in = sram_rdata;
      end
      S_WRITE: begin
        sram_addr     = state_base + ADDR_W'(idx);
        sram_write_en = 1'b1;
        sram_wdata    = byte_q;
      end
      S_KEY: begin
        sbox_en = 1'b1;
        sbox_in = key_word[{k, 3'b000} +: 8];
      end
      S_KACK: key_ack = 1'b1;
      S_DONE: sbytes_finished = 1'b1;
      default: ;
    endcase
  end

  assign key_result = key_result_q;

endmodule

`default_nettype wire

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched: a driver queues expected acks/finish pulses,
// a negedge monitor pops and compares them when the DUT raises them.
`default_nettype none

module tb_sbox_sched;
  import aes_pkg::*;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              sbytes_enable = 1'b0;
  logic [ADDR_W-1:0] state_base = '0;
  logic              sbytes_finished;
  logic              key_req = 1'b0;
  logic [31:0]       key_word = 32'h0;
  logic              key_ack;
  logic [31:0]       key_result;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_read_en;
  logic              sram_write_en;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata = 8'h00;
  logic              sbox_en;
  logic [7:0]        sbox_in;
  logic [7:0]        sbox_out;

  sbox_sched #(.ADDR_W(ADDR_W), .NBYTES(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .sbytes_enable(sbytes_enable), .state_base(state_base), .sbytes_finished(sbytes_finished),
    .key_req(key_req), .key_word(key_word), .key_ack(key_ack), .key_result(key_result),
    .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sbox_en(sbox_en), .sbox_in(sbox_in), .sbox_out(sbox_out)
  );

  assign sbox_out = sbox_ref(sbox_in);

  localparam logic [7:0] EXP0 [16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                                       8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
  localparam logic [7:0] EXPW [16] = '{8'h41, 8'h99, 8'h2D, 8'h0F, 8'hB0, 8'h54, 8'hBB, 8'h16,
                                       8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5};
  localparam logic [31:0] KEY_IN  = 32'h5302_0100;
  localparam logic [31:0] KEY_EXP = 32'hED77_7C63;

  typedef struct { int cyc; logic [31:0] val; } exp_t;
  exp_t kq[$];
  exp_t fq[$];

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_log[$];
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int viol = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_read_en) begin
      sram_rdata <= mem[sram_addr];
      rd_cnt     <= rd_cnt + 1;
    end
    if (sram_write_en) begin
      mem[sram_addr] <= sram_wdata;
      wr_cnt         <= wr_cnt + 1;
      wr_log.push_back(sram_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if ((sram_read_en && sram_write_en) ||
          (!sram_read_en && !sram_write_en && sram_addr != '0) ||
          (sbox_en && (sram_read_en || sram_write_en)))
        viol <= viol + 1;
      if (key_ack) begin
        chk("ack_expected", 32'(kq.size() > 0), 32'd1);
        if (kq.size() > 0) begin
          e = kq.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("key_result", key_result, e.val);
        end
      end
      if (sbytes_finished) begin
        chk("finish_expected", 32'(fq.size() > 0), 32'd1);
        if (fq.size() > 0) begin
          e = fq.pop_front();
          chk("finish_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic fill(input logic [15:0] base, input logic [7:0] first);
    for (int i = 0; i < 16; i++) mem[16'(base + 16'(i))] = 8'(first + 8'(i));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (kq.size() == 0 && fq.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("scoreboard_drained", 32'(kq.size() + fq.size()), 32'd0);
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (key_ack) break;
      @(negedge clk);
    end
    chk("ack_seen", 32'(key_ack), 32'd1);
  endtask

  task automatic check_mem(input string nm, input logic [15:0] base, input int wrap);
    for (int i = 0; i < 16; i++)
      chk(nm, 32'(mem[16'(base + 16'(i))]), 32'(wrap != 0 ? EXPW[i] : EXP0[i]));
  endtask

  task automatic start_pass(input logic [15:0] base, input int fin_ofs, output int t0);
    state_base = base;
    t0 = cyc;
    fq.push_back('{t0 + fin_ofs, 32'h0});
    sbytes_enable = 1'b1;
    @(negedge clk);
    sbytes_enable = 1'b0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk(nm, {sram_addr, sram_read_en, sram_write_en, sram_wdata, sbox_en, sbox_in,
             sbytes_finished, key_ack}, 32'h0);
  endtask

  initial begin
    int t0, r0, w0, v0;
    key_word = KEY_IN;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    chk("reset_key_result", key_result, 32'h0);

    // Pass alone
    fill(16'h0100, 8'h00);
    r0 = rd_cnt; w0 = wr_cnt; v0 = viol;
    start_pass(16'h0100, 49, t0);
    drain(80);
    check_mem("pass_byte", 16'h0100, 0);
    chk("pass_reads", 32'(rd_cnt - r0), 32'd16);
    chk("pass_writes", 32'(wr_cnt - w0), 32'd16);
    chk("strobe_rules_pass", 32'(viol - v0), 32'd0);

    // Key alone
    t0 = cyc;
    kq.push_back('{t0 + 5, KEY_EXP});
    key_req = 1'b1;
    wait_ack(20);
    key_req = 1'b0;
    drain(20);

    // Simultaneous start: key first, pass afterwards
    fill(16'h0100, 8'h00);
    state_base = 16'h0100;
    t0 = cyc;
    kq.push_back('{t0 + 5, KEY_EXP});
    fq.push_back('{t0 + 54, 32'h0});
    sbytes_enable = 1'b1;
    key_req = 1'b1;
    @(negedge clk);
    sbytes_enable = 1'b0;
    wait_ack(20);
    key_req = 1'b0;
    drain(80);
    check_mem("simul_byte", 16'h0100, 0);

    // Fairness: key_req held through the pass; services after bytes 0,2,...,14
    fill(16'h0400, 8'h00);
    r0 = rd_cnt; w0 = wr_cnt; v0 = viol;
    state_base = 16'h0400;
    t0 = cyc;
    fq.push_back('{t0 + 89, 32'h0});
    for (int m = 0; m < 8; m++) kq.push_back('{t0 + 8 + 11 * m, KEY_EXP});
    sbytes_enable = 1'b1;
    @(negedge clk);
    sbytes_enable = 1'b0;
    key_req = 1'b1;
    for (int m = 0; m < 8; m++) begin
      wait_ack(30);
      if (m == 7) key_req = 1'b0;
      @(negedge clk);
    end
    drain(40);
    check_mem("fair_byte", 16'h0400, 0);
    chk("fair_reads", 32'(rd_cnt - r0), 32'd16);
    chk("fair_writes", 32'(wr_cnt - w0), 32'd16);
    chk("strobe_rules_fair", 32'(viol - v0), 32'd0);

    // Address wrap
    fill(16'hFFF8, 8'hF8);
    w0 = wr_log.size();
    start_pass(16'hFFF8, 49, t0);
    drain(80);
    check_mem("wrap_byte", 16'hFFF8, 1);
    chk("wrap_write_count", 32'(wr_log.size() - w0), 32'd16);
    for (int i = 0; i < 16; i++)
      if (w0 + i < wr_log.size()) chk("wrap_write_addr", 32'(wr_log[w0 + i]), 32'(16'(16'hFFF8 + 16'(i))));

    // Reset mid-pass
    fill(16'h0200, 8'h00);
    state_base = 16'h0200;
    t0 = cyc;
    sbytes_enable = 1'b1;
    @(negedge clk);
    sbytes_enable = 1'b0;
    while (cyc < t0 + 20) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("midreset_outputs");
    chk("midreset_key_result", key_result, 32'h0);
    chk("midreset_byte5_written", 32'(mem[16'h0205]), 32'h6B);
    chk("midreset_byte6_untouched", 32'(mem[16'h0206]), 32'h06);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("midreset_no_finish", 32'(mem[16'h0206]), 32'h06);
    fill(16'h0300, 8'h00);
    start_pass(16'h0300, 49, t0);
    drain(80);
    check_mem("post_reset_byte", 16'h0300, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
